rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 4, meaning the number of requesters (power of 2, minimum 2).
REQ-002 SHALL have parameter DATA_LEN, default 8, meaning the payload width per requester.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of beats per grant (minimum 1).
REQ-004 SHALL use one clock and a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-005 SHALL have these ports:
  clk  in  1  system clock
  rst_n  in  1  synchronous reset, active low
  req_valid  in  NR_REQ  per-requester beat valid
  req_last  in  NR_REQ  per-requester last-beat marker, qualified by req_valid
  req_data  in  NR_REQ*DATA_LEN  packed payloads; requester n occupies bits [DATA_LEN*(n+1)-1 : DATA_LEN*n]
  req_ready  out  NR_REQ  per-requester beat accept
  out_valid  out  1  shared-port beat valid
  out_data  out  DATA_LEN  shared-port payload
  out_last  out  1  shared-port last-beat marker
  out_ready  in  1  downstream accept
  out_src  out  clog2(NR_REQ)  index of the current grant holder
  busy  out  1  high while a grant is held

Function
REQ-006 SHALL implement a two-state FSM, IDLE and XFER.
REQ-007 IDLE: out_valid=0, out_last=0, out_data=0, req_ready=0.
REQ-008 IDLE with any req_valid high: the winner SHALL be the first index with req_valid high, searching ptr, ptr+1, ... modulo NR_REQ; the next state SHALL be XFER, grant=winner, and beat count=0.
REQ-009 IDLE with no req_valid high: the FSM SHALL stay in IDLE; ptr and grant SHALL hold.
REQ-010 Arbitration latency SHALL be exactly 1 cycle, from req_valid seen in IDLE to the first cycle of XFER.
REQ-011 XFER outputs SHALL be combinational pass-through from the grant holder g, with no added latency:
  out_valid=req_valid[g]
  out_data=req_data slice g when req_valid[g]=1, else 0
  out_last=req_valid[g] & (req_last[g] | count==MAX_BURST-1)
  req_ready[g]=out_ready
  all other req_ready bits 0
REQ-012 A beat SHALL be transferred in a cycle where XFER, out_valid=1 and out_ready=1; each transferred beat SHALL increment count.
REQ-013 A transferred beat with out_last=1 SHALL end the grant: next state IDLE, ptr=(g+1) mod NR_REQ (wrapping NR_REQ-1 to 0), count=0.
REQ-014 A grant SHALL never be preempted; if req_valid[g] drops in XFER, the FSM SHALL stay in XFER with out_valid=0 until g completes.
REQ-015 req_ready from non-granted requesters SHALL stay 0 regardless of their req_valid, and their requests SHALL be held pending.
REQ-016 out_src SHALL equal the grant register in all states, holding its last value in IDLE.
REQ-017 busy SHALL be 1 exactly when the state is XFER.
REQ-018 There SHALL be exactly one IDLE cycle between consecutive grants.
REQ-019 With MAX_BURST=1, every transferred beat SHALL end the grant.
REQ-020 out_ready high in IDLE SHALL have no effect.
REQ-021 out_ready SHALL be allowed to toggle arbitrarily in XFER; a beat held with out_valid=1 and out_ready=0 SHALL keep out_data stable provided the requester holds it.
REQ-022 count SHALL be clog2(MAX_BURST)+1 bits wide and SHALL never exceed MAX_BURST-1.

Reset
REQ-023 When rst_n=0 at a clock edge, the next state SHALL be state=IDLE, ptr=0, grant=0, count=0, irrespective of current state.
REQ-024 Reset SHALL take effect from any state, including mid-burst; the partial burst SHALL be abandoned with no completion beat.
REQ-025 After reset the outputs SHALL be out_valid=0, out_last=0, out_data=0, req_ready=0, out_src=0, busy=0.

Verification
REQ-026 Single requester: req_valid=0100, req_data[2]=0xA5, req_last=1, out_ready=1 -> IDLE for 1 cycle; next cycle out_valid=1, out_data=0xA5, out_src=2, out_last=1, req_ready=0100; then IDLE with ptr=3.
REQ-027 All four requesting continuously, 1-beat packets, after reset -> grant order 0,1,2,3,0; one IDLE cycle between grants; ptr wraps 3 -> 0.
REQ-028 Requester 1 streams 6 beats with req_last never set, MAX_BURST=4 -> out_last=1 on beat 4; grant ends; requester 1 is re-granted after 1 IDLE cycle for the remaining beats if no other requester is valid.
REQ-029 Backpressure: grant on requester 0, out_ready=0 for 3 cycles then 1 -> out_data stable for 4 cycles; req_ready[0] high only in the 4th cycle; count increments once.
REQ-030 Reset mid-burst: requester 3 at beat 2 of 4, rst_n=0 for 1 cycle -> next cycle busy=0, out_valid=0, out_src=0; with requesters 3 and 0 valid, the next grant goes to requester 0.
REQ-031 Holder stall: grant on requester 2, req_valid[2]=0 for 2 cycles while requester 1 is valid -> busy=1, out_valid=0, req_ready=0000; no switch to requester 1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 packet multiplexer. A grant persists until the holder
// completes a packet or hits the burst limit, then the priority rotates.
module rr_mux_arbiter #(
    parameter int unsigned NR_REQ    = 4,
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NR_REQ-1:0]            req_valid,
    input  logic [NR_REQ-1:0]            req_last,
    input  logic [NR_REQ*DATA_LEN-1:0]   req_data,
    output logic [NR_REQ-1:0]            req_ready,
    output logic                         out_valid,
    output logic [DATA_LEN-1:0]          out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [$clog2(NR_REQ)-1:0]    out_src,
    output logic                         busy
);

    localparam int unsigned IDX_W = $clog2(NR_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant;
    logic [CNT_W-1:0]   count;

    logic               any_valid;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic [DATA_LEN-1:0] sel_data;
    logic               burst_end;
    logic               beat_done;

    // Rotating priority search: walk from the far end so the lowest offset from ptr wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = ptr;
        idx       = ptr;
        for (int i = int'(NR_REQ) - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int n = 0; n < int'(NR_REQ); n++) begin
            if (grant == IDX_W'(n)) begin
                sel_data = req_data[n*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Shared port is a zero-latency pass-through of the grant holder while in XFER.
    always_comb begin
        burst_end = (count == CNT_W'(MAX_BURST - 1));
        out_valid = (state == XFER) && req_valid[grant];
        out_last  = out_valid && (req_last[grant] || burst_end);
        out_data  = out_valid ? sel_data : '0;
        beat_done = out_valid && out_ready;
        req_ready = '0;
        for (int n = 0; n < int'(NR_REQ); n++) begin
            req_ready[n] = (state == XFER) && (grant == IDX_W'(n)) && out_ready;
        end
    end

    assign out_src = grant;
    assign busy    = (state == XFER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state <= XFER;
                        grant <= winner;
                        count <= '0;
                    end
                end
                XFER: begin
                    if (beat_done) begin
                        if (out_last) begin
                            state <= IDLE;
                            ptr   <= grant + IDX_W'(1);
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
